// File: rtl/demux_rr_dispatcher_pkg.sv
// Shared constants and types for the 1-to-4 demultiplex dispatcher.
package demux_pkg;

    localparam int   N_CH       = 4;
    localparam int   SEL_W      = 2;
    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/demux_rr_dispatcher_rr_pick4.sv
// Rotating-priority picker: first set bit of mask scanning ptr+1, ptr+2, ... (mod 4).
module rr_pick4
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0] ptr_i,
    input  logic [N_CH-1:0]  mask_i,
    output logic [SEL_W-1:0] grant_o,
    output logic             any_o
);

    logic [SEL_W-1:0] cand;

    // Scan from farthest to nearest so the nearest enabled channel overwrites the rest
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int k = N_CH; k >= 1; k--) begin
            cand = ptr_i + SEL_W'(k);
            if (mask_i[cand]) begin
                grant_o = cand;
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// One-input, four-output dispatcher with a single registered output slot.
// Words go round-robin over enabled channels or to a fixed channel.
module demux_rr_dispatcher
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  cfg_mode,
    input  logic [SEL_W-1:0]      cfg_sel,
    input  logic [N_CH-1:0]       cfg_en,
    output logic [N_CH-1:0]       out_valid,
    input  logic [N_CH-1:0]       out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic [N_CH*CNT_W-1:0] cnt_dump
);

    state_t             state_q;
    logic [DATA_W-1:0]  data_q;
    logic [SEL_W-1:0]   sel_q;
    logic [N_CH-1:0]    valid_q;
    logic [SEL_W-1:0]   rr_ptr_q;
    logic [CNT_W-1:0]   cnt_q [N_CH];
    logic [CNT_W-1:0]   cnt_d [N_CH];

    logic [SEL_W-1:0]   rr_grant;
    logic               rr_any;
    logic [SEL_W-1:0]   target;
    logic               target_ok;
    logic               deliver;
    logic               accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    rr_pick4 u_pick (
        .ptr_i   (rr_ptr_q),
        .mask_i  (cfg_en),
        .grant_o (rr_grant),
        .any_o   (rr_any)
    );

    // Handshake decode; in_ready sees out_ready so a full slot can refill in the delivering cycle
    always_comb begin
        target    = (cfg_mode == MODE_FIXED) ? cfg_sel : rr_grant;
        target_ok = (cfg_mode == MODE_FIXED) | rr_any;
        deliver   = (state_q == FULL) & out_ready[sel_q];
        in_ready  = ((state_q == EMPTY) | deliver) & target_ok;
        accept    = in_valid & in_ready;
    end

    // Output-slot FSM; cfg is sampled only when a word is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            data_q   <= '0;
            sel_q    <= '0;
            valid_q  <= '0;
            rr_ptr_q <= SEL_W'(N_CH - 1);
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q <= FULL;
                        data_q  <= in_data;
                        sel_q   <= target;
                        valid_q <= N_CH'(1) << target;
                        if (cfg_mode == MODE_RR) rr_ptr_q <= rr_grant;
                    end
                end
                FULL: begin
                    if (accept) begin
                        data_q  <= in_data;
                        sel_q   <= target;
                        valid_q <= N_CH'(1) << target;
                        if (cfg_mode == MODE_RR) rr_ptr_q <= rr_grant;
                    end else if (deliver) begin
                        state_q <= EMPTY;
                        valid_q <= '0;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    valid_q <= '0;
                end
            endcase
        end
    end

    // Next-state for the per-channel saturating delivery counters
    always_comb begin
        cnt_d = cnt_q;
        if (deliver) cnt_d[sel_q] = sat_inc(cnt_q[sel_q]);
    end

    // Delivery counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_dump
        assign cnt_dump[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule
